// File: rtl/conv_row_sched.sv
// Row scheduler for the 3x3 edge-detection window: rotates incoming rows across
// three line buffers and sweeps them in lockstep, padding the top/bottom image edges.
module conv_row_sched #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_sof,
  output logic       in_ready,
  output logic [2:0] buf_wr_en,
  output logic [2:0] buf_rst,
  output logic       buf_rd_en,
  output logic [1:0] sel_top,
  output logic [1:0] sel_mid,
  output logic [1:0] sel_bot,
  output logic       pad_top,
  output logic       pad_bot,
  output logic       win_valid,
  output logic [9:0] win_col,
  output logic [8:0] win_row,
  output logic       frame_done
);

  localparam logic [9:0] LAST_COL  = 10'(IMG_W - 1);
  localparam logic [8:0] LAST_ROW  = 9'(IMG_H - 1);
  localparam logic [9:0] FULL_ROWS = 10'(IMG_H);

  typedef enum logic [2:0] {IDLE, FILL, SWEEP, PRST, ABORT} state_t;

  state_t     state, state_nxt;
  logic [9:0] fill_col, fill_col_nxt;
  logic [9:0] fill_row, fill_row_nxt;
  logic [9:0] out_col, out_col_nxt;
  logic [8:0] out_row, out_row_nxt;
  logic [1:0] wb, wb_nxt;
  logic [1:0] row_mod, row_mod_nxt;

  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  function automatic logic [1:0] dec3(input logic [1:0] v);
    return (v == 2'd0) ? 2'd2 : v - 2'd1;
  endfunction

  // row_mod tracks out_row mod 3 so buffer selection needs no divider
  assign sel_mid = row_mod;
  assign sel_top = dec3(row_mod);
  assign sel_bot = inc3(row_mod);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fill_col <= '0;
      fill_row <= '0;
      out_col  <= '0;
      out_row  <= '0;
      wb       <= '0;
      row_mod  <= '0;
    end else begin
      state    <= state_nxt;
      fill_col <= fill_col_nxt;
      fill_row <= fill_row_nxt;
      out_col  <= out_col_nxt;
      out_row  <= out_row_nxt;
      wb       <= wb_nxt;
      row_mod  <= row_mod_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    fill_col_nxt = fill_col;
    fill_row_nxt = fill_row;
    out_col_nxt  = out_col;
    out_row_nxt  = out_row;
    wb_nxt       = wb;
    row_mod_nxt  = row_mod;
    in_ready     = 1'b0;
    buf_wr_en    = 3'b000;
    buf_rst      = 3'b000;
    buf_rd_en    = 1'b0;
    win_valid    = 1'b0;
    win_col      = '0;
    win_row      = '0;
    pad_top      = 1'b0;
    pad_bot      = 1'b0;
    frame_done   = 1'b0;

    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid && in_sof) begin
          buf_wr_en    = 3'b001;
          fill_col_nxt = 10'd1;
          fill_row_nxt = '0;
          wb_nxt       = 2'd0;
          state_nxt    = FILL;
        end
      end

      FILL: begin
        // A new frame start mid-fill is held off and restarts the frame via ABORT
        if (in_valid && in_sof && !(fill_row == '0 && fill_col == '0)) begin
          state_nxt = ABORT;
        end else begin
          in_ready = 1'b1;
          if (in_valid) begin
            buf_wr_en = 3'b001 << wb;
            if (fill_col == LAST_COL) begin
              fill_col_nxt = '0;
              fill_row_nxt = fill_row + 10'd1;
              wb_nxt       = inc3(wb);
              if (fill_row_nxt >= 10'd2) state_nxt = SWEEP;
            end else begin
              fill_col_nxt = fill_col + 10'd1;
            end
          end
        end
      end

      SWEEP: begin
        buf_rd_en = 1'b1;
        win_valid = 1'b1;
        win_col   = out_col;
        win_row   = out_row;
        pad_top   = (out_row == '0);
        pad_bot   = (out_row == LAST_ROW);
        if (out_col == LAST_COL) state_nxt = PRST;
        else out_col_nxt = out_col + 10'd1;
      end

      PRST: begin
        buf_rst     = 3'b111;
        out_col_nxt = '0;
        if (out_row == LAST_ROW) begin
          frame_done   = 1'b1;
          state_nxt    = IDLE;
          fill_col_nxt = '0;
          fill_row_nxt = '0;
          out_row_nxt  = '0;
          wb_nxt       = 2'd0;
          row_mod_nxt  = 2'd0;
        end else begin
          out_row_nxt = out_row + 9'd1;
          row_mod_nxt = inc3(row_mod);
          // Once every row is buffered, the bottom row sweeps without a fill
          state_nxt   = (fill_row == FULL_ROWS) ? SWEEP : FILL;
        end
      end

      ABORT: begin
        buf_rst      = 3'b111;
        fill_col_nxt = '0;
        fill_row_nxt = '0;
        out_col_nxt  = '0;
        out_row_nxt  = '0;
        wb_nxt       = 2'd0;
        row_mod_nxt  = 2'd0;
        state_nxt    = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule
